// File: rtl/control_pkg.sv
// Shared opcode, ALUOp and forward-select encodings plus the
// packed control bundle carried down the control pipeline.
package control_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALU_R   = 2'd0;
   localparam logic [1:0] ALU_I   = 2'd1;
   localparam logic [1:0] ALU_BR  = 2'd2;
   localparam logic [1:0] ALU_OTH = 2'd3;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_WB  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       branch;
      logic       jal;
      logic       jalr;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_pipe_if.sv
// ID-side instruction inputs, hazard inputs and the staged
// control outputs of control_pipe, bundled as one interface.
interface control_pipe_if #(
   parameter int REG_AW = 5
);
   logic [31:0]       Instr_i;
   logic              Valid_i;
   logic              Flush_i;
   logic              MemReady_i;
   logic              Stall_o;
   logic              Illegal_o;
   logic [1:0]        ALUOp_o;
   logic              ALUSrc_o;
   logic              Branch_o;
   logic              Jal_o;
   logic              Jalr_o;
   logic              MemRead_o;
   logic              MemWrite_o;
   logic              RegWrite_o;
   logic              MemtoReg_o;
   logic [REG_AW-1:0] WbRd_o;
   logic [1:0]        ForwardA_o;
   logic [1:0]        ForwardB_o;

   modport master (
      output Instr_i, Valid_i, Flush_i, MemReady_i,
      input  Stall_o, Illegal_o, ALUOp_o, ALUSrc_o,
      input  Branch_o, Jal_o, Jalr_o, MemRead_o,
      input  MemWrite_o, RegWrite_o, MemtoReg_o,
      input  WbRd_o, ForwardA_o, ForwardB_o
   );

   modport slave (
      input  Instr_i, Valid_i, Flush_i, MemReady_i,
      output Stall_o, Illegal_o, ALUOp_o, ALUSrc_o,
      output Branch_o, Jal_o, Jalr_o, MemRead_o,
      output MemWrite_o, RegWrite_o, MemtoReg_o,
      output WbRd_o, ForwardA_o, ForwardB_o
   );

endinterface

// File: rtl/control_dec.sv
// Combinational RV32I opcode decoder: control bundle,
// illegal flag and rs1/rs2 use flags.
module control_dec
   import control_pkg::*;
(
   input  logic [6:0] opcode_i,
   output ctrl_t      ctrl_o,
   output logic       illegal_o,
   output logic       use_rs1_o,
   output logic       use_rs2_o
);

   always_comb begin
      ctrl_o    = CTRL_NOP;
      illegal_o = 1'b0;
      use_rs1_o = 1'b0;
      use_rs2_o = 1'b0;
      unique case (1'b1)
         (opcode_i == OP_R): begin
            ctrl_o.alu_op    = ALU_R;
            ctrl_o.reg_write = 1'b1;
            use_rs1_o        = 1'b1;
            use_rs2_o        = 1'b1;
         end
         (opcode_i == OP_IALU): begin
            ctrl_o.alu_op    = ALU_I;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            use_rs1_o        = 1'b1;
         end
         (opcode_i == OP_LOAD): begin
            ctrl_o.alu_op     = ALU_OTH;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.mem_read   = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            use_rs1_o         = 1'b1;
         end
         (opcode_i == OP_STORE): begin
            ctrl_o.alu_op    = ALU_OTH;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.mem_write = 1'b1;
            use_rs1_o        = 1'b1;
            use_rs2_o        = 1'b1;
         end
         (opcode_i == OP_BRANCH): begin
            ctrl_o.alu_op = ALU_BR;
            ctrl_o.branch = 1'b1;
            use_rs1_o     = 1'b1;
            use_rs2_o     = 1'b1;
         end
         (opcode_i == OP_JALR): begin
            ctrl_o.alu_op    = ALU_OTH;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.jalr      = 1'b1;
            ctrl_o.reg_write = 1'b1;
            use_rs1_o        = 1'b1;
         end
         (opcode_i == OP_JAL): begin
            ctrl_o.alu_op    = ALU_OTH;
            ctrl_o.jal       = 1'b1;
            ctrl_o.reg_write = 1'b1;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control unit: ID decode, EX/MEM/WB control stages, hazards.
// Define CONTROL_PIPE_FWD_EN for EX forwarding; otherwise ID stalls on RAW.
module control_pipe
   import control_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter bit X0_ZERO = 1'b1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   control_pipe_if.slave  bus
);

   typedef logic [REG_AW-1:0] reg_t;

   typedef struct packed {
      logic  valid;
      ctrl_t ctrl;
      reg_t  rd;
      reg_t  rs1;
      reg_t  rs2;
      logic  use1;
      logic  use2;
   } ex_t;

   typedef struct packed {
      logic  valid;
      ctrl_t ctrl;
      reg_t  rd;
   } st_t;

   ex_t ex_q, ex_d;
   st_t mem_q, mem_d;
   st_t wb_q, wb_d;

   ctrl_t id_ctrl;
   logic  id_illegal;
   logic  id_use1;
   logic  id_use2;
   logic  id_valid;
   reg_t  id_rd;
   reg_t  id_rs1;
   reg_t  id_rs2;
   logic  freeze;
   logic  hazard;

   control_dec u_dec (
      .opcode_i  (bus.Instr_i[6:0]),
      .ctrl_o    (id_ctrl),
      .illegal_o (id_illegal),
      .use_rs1_o (id_use1),
      .use_rs2_o (id_use2)
   );

   assign id_rd    = bus.Instr_i[7 +: REG_AW];
   assign id_rs1   = bus.Instr_i[15 +: REG_AW];
   assign id_rs2   = bus.Instr_i[20 +: REG_AW];
   assign id_valid = bus.Valid_i & ~id_illegal;

   // rd==x0 never counts as a real write when X0_ZERO is set
   function automatic logic writes(
      input logic v, input ctrl_t c, input reg_t rd
   );
      return v && c.reg_write && !(X0_ZERO && rd == '0);
   endfunction

   function automatic logic hit(
      input logic v, input ctrl_t c, input reg_t rd,
      input reg_t src
   );
      return writes(v, c, rd) && (rd == src);
   endfunction

   assign freeze = mem_q.valid
                 & (mem_q.ctrl.mem_read | mem_q.ctrl.mem_write)
                 & ~bus.MemReady_i;

`ifdef CONTROL_PIPE_FWD_EN
   function automatic logic [1:0] fsel(
      input logic u, input reg_t src,
      input st_t m, input st_t w
   );
      if (!u)
         return FWD_RF;
      if (hit(m.valid, m.ctrl, m.rd, src))
         return FWD_MEM;
      if (hit(w.valid, w.ctrl, w.rd, src))
         return FWD_WB;
      return FWD_RF;
   endfunction

   logic ld_use;

   always_comb begin
      ld_use = 1'b0;
      if (id_valid && ex_q.valid && ex_q.ctrl.mem_read)
         ld_use =
            (id_use1 && hit(1'b1, ex_q.ctrl, ex_q.rd, id_rs1)) ||
            (id_use2 && hit(1'b1, ex_q.ctrl, ex_q.rd, id_rs2));
   end

   assign hazard = ld_use;

   assign bus.ForwardA_o = ex_q.valid
      ? fsel(ex_q.use1, ex_q.rs1, mem_q, wb_q) : FWD_RF;
   assign bus.ForwardB_o = ex_q.valid
      ? fsel(ex_q.use2, ex_q.rs2, mem_q, wb_q) : FWD_RF;
`else
   logic raw1;
   logic raw2;
   logic unused_ex;

   // WB is absent: the regfile writes before it is read
   always_comb begin
      raw1 = id_use1 && (
         hit(ex_q.valid, ex_q.ctrl, ex_q.rd, id_rs1) ||
         hit(mem_q.valid, mem_q.ctrl, mem_q.rd, id_rs1));
      raw2 = id_use2 && (
         hit(ex_q.valid, ex_q.ctrl, ex_q.rd, id_rs2) ||
         hit(mem_q.valid, mem_q.ctrl, mem_q.rd, id_rs2));
   end

   assign hazard    = id_valid & (raw1 | raw2);
   assign unused_ex = ^{ex_q.rs1, ex_q.rs2, ex_q.use1, ex_q.use2};

   assign bus.ForwardA_o = FWD_RF;
   assign bus.ForwardB_o = FWD_RF;
`endif

   assign bus.Stall_o   = freeze | (hazard & ~bus.Flush_i);
   assign bus.Illegal_o = bus.Valid_i & id_illegal;

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!freeze) begin
         wb_d  = mem_q;
         mem_d = '{valid: ex_q.valid, ctrl: ex_q.ctrl,
                   rd: ex_q.rd};
         ex_d  = '{valid: id_valid,
                   ctrl:  id_valid ? id_ctrl : CTRL_NOP,
                   rd:    id_rd,
                   rs1:   id_rs1,
                   rs2:   id_rs2,
                   use1:  id_use1,
                   use2:  id_use2};
         if (bus.Flush_i || hazard)
            ex_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   ctrl_t ex_c;
   ctrl_t mem_c;
   ctrl_t wb_c;

   assign ex_c  = ex_q.valid  ? ex_q.ctrl  : CTRL_NOP;
   assign mem_c = mem_q.valid ? mem_q.ctrl : CTRL_NOP;
   assign wb_c  = wb_q.valid  ? wb_q.ctrl  : CTRL_NOP;

   assign bus.ALUOp_o    = ex_c.alu_op;
   assign bus.ALUSrc_o   = ex_c.alu_src;
   assign bus.Branch_o   = ex_c.branch;
   assign bus.Jal_o      = ex_c.jal;
   assign bus.Jalr_o     = ex_c.jalr;
   assign bus.MemRead_o  = mem_c.mem_read;
   assign bus.MemWrite_o = mem_c.mem_write;
   assign bus.RegWrite_o = writes(wb_q.valid, wb_q.ctrl, wb_q.rd);
   assign bus.MemtoReg_o = wb_c.mem_to_reg;
   assign bus.WbRd_o     = wb_q.valid ? wb_q.rd : '0;

   logic unused_instr;
   assign unused_instr = ^{bus.Instr_i[31:25], bus.Instr_i[14:12],
                           wb_c.alu_op, wb_c.alu_src, wb_c.branch,
                           wb_c.jal, wb_c.jalr, wb_c.mem_read,
                           wb_c.mem_write, wb_c.reg_write,
                           mem_c.alu_op, mem_c.alu_src, mem_c.branch,
                           mem_c.jal, mem_c.jalr, mem_c.reg_write,
                           mem_c.mem_to_reg, ex_c.mem_read,
                           ex_c.mem_write, ex_c.reg_write,
                           ex_c.mem_to_reg};

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: decode latency, hazards,
// forwarding, freeze, flush, x0 and illegal handling.
module tb_control_pipe;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   control_pipe_if #(.REG_AW(5)) bus ();

   control_pipe #(.REG_AW(5), .X0_ZERO(1'b1)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [20:0] outs;
   assign outs = {bus.Stall_o, bus.Illegal_o, bus.ALUOp_o,
                  bus.ALUSrc_o, bus.Branch_o, bus.Jal_o, bus.Jalr_o,
                  bus.MemRead_o, bus.MemWrite_o, bus.RegWrite_o,
                  bus.MemtoReg_o, bus.WbRd_o, bus.ForwardA_o,
                  bus.ForwardB_o};

   function automatic logic [31:0] e_add(input int rd, rs1, rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
   endfunction
   function automatic logic [31:0] e_addi(input int rd, rs1, imm);
      return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'b0010011};
   endfunction
   function automatic logic [31:0] e_lw(input int rd, rs1);
      return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
   endfunction
   function automatic logic [31:0] e_sw(input int rs2, rs1);
      return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
   endfunction
   function automatic logic [31:0] e_beq(input int rs1, rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'd0, 7'b1100011};
   endfunction
   function automatic logic [31:0] e_jal(input int rd);
      return {20'd8, 5'(rd), 7'b1101111};
   endfunction
   function automatic logic [31:0] e_jalr(input int rd, rs1);
      return {12'd0, 5'(rs1), 3'd0, 5'(rd), 7'b1100111};
   endfunction

   // one cycle: inputs change just after the edge, outputs read at negedge
   task automatic cyc(input logic [31:0] ins, input logic v = 1'b1,
                      input logic fl = 1'b0, input logic mr = 1'b1,
                      input logic rs = 1'b0);
      @(posedge clk);
      #1;
      bus.Instr_i    = ins;
      bus.Valid_i    = v;
      bus.Flush_i    = fl;
      bus.MemReady_i = mr;
      rst            = rs;
      @(negedge clk);
   endtask

   task automatic drain();
      repeat (4) cyc(32'h0, 1'b0);
   endtask

   task automatic test_reset();
      cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== 21'd0) begin
         errors++;
         $display("FAIL reset_outs: got %h exp 0", outs);
      end
      cyc(e_add(3, 1, 2));
      checks++;
      if (bus.Stall_o !== 1'b0) begin
         errors++;
         $display("FAIL add_stall: got %b exp 0", bus.Stall_o);
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.ALUOp_o, bus.ALUSrc_o} !== 3'b000) begin
         errors++;
         $display("FAIL add_ex: got %b exp 000",
                  {bus.ALUOp_o, bus.ALUSrc_o});
      end
      cyc(32'h0, 1'b0);
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.RegWrite_o, bus.WbRd_o} !== {1'b1, 5'd3}) begin
         errors++;
         $display("FAIL add_wb: got %b/%0d exp 1/3",
                  bus.RegWrite_o, bus.WbRd_o);
      end
      drain();
   endtask

   task automatic test_load_use();
      logic [31:0] add_i;
      add_i = e_add(6, 5, 2);
      cyc(e_lw(5, 1));
      cyc(add_i);
      checks++;
      if ({bus.Stall_o, bus.ALUOp_o, bus.ALUSrc_o} !== 4'b1111) begin
         errors++;
         $display("FAIL lu_c2: got %b exp 1111",
                  {bus.Stall_o, bus.ALUOp_o, bus.ALUSrc_o});
      end
      cyc(add_i);
      checks++;
      if ({bus.ALUSrc_o, bus.MemRead_o} !== 2'b01) begin
         errors++;
         $display("FAIL lu_bubble: got %b exp 01",
                  {bus.ALUSrc_o, bus.MemRead_o});
      end
`ifdef CONTROL_PIPE_FWD_EN
      checks++;
      if (bus.Stall_o !== 1'b0) begin
         errors++;
         $display("FAIL lu_c3_stall: got %b exp 0", bus.Stall_o);
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.ForwardA_o, bus.ForwardB_o} !== 4'b0100) begin
         errors++;
         $display("FAIL lu_fwd: got %b exp 0100",
                  {bus.ForwardA_o, bus.ForwardB_o});
      end
`else
      checks++;
      if (bus.Stall_o !== 1'b1) begin
         errors++;
         $display("FAIL lu_c3_stall: got %b exp 1", bus.Stall_o);
      end
      cyc(add_i);
      checks++;
      if (bus.Stall_o !== 1'b0) begin
         errors++;
         $display("FAIL lu_c4_stall: got %b exp 0", bus.Stall_o);
      end
`endif
      checks++;
      if ({bus.RegWrite_o, bus.MemtoReg_o, bus.WbRd_o}
          !== {2'b11, 5'd5}) begin
         errors++;
         $display("FAIL lu_wb: got %b/%b/%0d exp 1/1/5",
                  bus.RegWrite_o, bus.MemtoReg_o, bus.WbRd_o);
      end
`ifndef CONTROL_PIPE_FWD_EN
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.ALUOp_o, bus.ForwardA_o, bus.ForwardB_o} !== 6'd0) begin
         errors++;
         $display("FAIL lu_ex: got %b exp 0",
                  {bus.ALUOp_o, bus.ForwardA_o, bus.ForwardB_o});
      end
`endif
      drain();
   endtask

   task automatic test_fwd_priority();
      logic [31:0] add_i;
      int          stalls;
      add_i  = e_add(7, 4, 4);
      stalls = 0;
      cyc(e_addi(4, 0, 1));
      cyc(e_addi(4, 0, 2));
      checks++;
      if (bus.Stall_o !== 1'b0) begin
         errors++;
         $display("FAIL fp_addi_stall: got %b exp 0", bus.Stall_o);
      end
      cyc(add_i);
`ifdef CONTROL_PIPE_FWD_EN
      checks++;
      if (bus.Stall_o !== 1'b0) begin
         errors++;
         $display("FAIL fp_stall: got %b exp 0", bus.Stall_o);
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.ForwardA_o, bus.ForwardB_o} !== 4'b1010) begin
         errors++;
         $display("FAIL fp_fwd: got %b exp 1010",
                  {bus.ForwardA_o, bus.ForwardB_o});
      end
`else
      for (int i = 0; i < 3; i++) begin
         if (bus.Stall_o === 1'b1)
            stalls++;
         cyc(add_i);
      end
      checks++;
      if (stalls !== 2) begin
         errors++;
         $display("FAIL fp_stalls: got %0d exp 2", stalls);
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.ForwardA_o, bus.ForwardB_o, bus.ALUSrc_o} !== 5'd0) begin
         errors++;
         $display("FAIL fp_nofwd: got %b exp 0",
                  {bus.ForwardA_o, bus.ForwardB_o, bus.ALUSrc_o});
      end
`endif
      drain();
   endtask

   task automatic test_freeze();
      logic [31:0] add_i;
      int          stalls;
      add_i  = e_add(8, 1, 2);
      stalls = 0;
      cyc(e_sw(2, 1));
      cyc(e_addi(9, 1, 5));
      for (int i = 0; i < 3; i++) begin
         cyc(add_i, 1'b1, (i != 1), 1'b0);
         if (bus.Stall_o === 1'b1)
            stalls++;
         checks++;
         if ({bus.ALUOp_o, bus.ALUSrc_o, bus.MemWrite_o,
              bus.RegWrite_o} !== 5'b01110) begin
            errors++;
            $display("FAIL frz_hold%0d: got %b exp 01110", i,
                     {bus.ALUOp_o, bus.ALUSrc_o, bus.MemWrite_o,
                      bus.RegWrite_o});
         end
      end
      checks++;
      if (stalls !== 3) begin
         errors++;
         $display("FAIL frz_stalls: got %0d exp 3", stalls);
      end
      cyc(add_i);
      checks++;
      if ({bus.Stall_o, bus.ALUOp_o, bus.MemWrite_o} !== 4'b0011) begin
         errors++;
         $display("FAIL frz_release: got %b exp 0011",
                  {bus.Stall_o, bus.ALUOp_o, bus.MemWrite_o});
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.ALUOp_o, bus.ALUSrc_o, bus.MemWrite_o,
           bus.RegWrite_o} !== 5'd0) begin
         errors++;
         $display("FAIL frz_after: got %b exp 0",
                  {bus.ALUOp_o, bus.ALUSrc_o, bus.MemWrite_o,
                   bus.RegWrite_o});
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.RegWrite_o, bus.WbRd_o} !== {1'b1, 5'd9}) begin
         errors++;
         $display("FAIL frz_addi_wb: got %b/%0d exp 1/9",
                  bus.RegWrite_o, bus.WbRd_o);
      end
      drain();
   endtask

   task automatic test_flush_vs_stall();
      cyc(e_lw(5, 1));
      cyc(e_add(6, 5, 0), 1'b1, 1'b1);
      checks++;
      if (bus.Stall_o !== 1'b0) begin
         errors++;
         $display("FAIL fl_stall: got %b exp 0", bus.Stall_o);
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o, bus.Jal_o,
           bus.Jalr_o, bus.MemRead_o} !== 7'b0000001) begin
         errors++;
         $display("FAIL fl_ex: got %b exp 0000001",
                  {bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o, bus.Jal_o,
                   bus.Jalr_o, bus.MemRead_o});
      end
      cyc(32'h0, 1'b0);
      cyc(32'h0, 1'b0);
      checks++;
      if (bus.RegWrite_o !== 1'b0) begin
         errors++;
         $display("FAIL fl_discard: got %b exp 0", bus.RegWrite_o);
      end
      drain();
   endtask

   task automatic test_x0_illegal();
      cyc(e_addi(0, 0, 1));
      cyc(e_add(1, 0, 0));
      checks++;
      if (bus.Stall_o !== 1'b0) begin
         errors++;
         $display("FAIL x0_stall: got %b exp 0", bus.Stall_o);
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.ForwardA_o, bus.ForwardB_o} !== 4'd0) begin
         errors++;
         $display("FAIL x0_fwd: got %b exp 0",
                  {bus.ForwardA_o, bus.ForwardB_o});
      end
      cyc(32'h0, 1'b0);
      checks++;
      if (bus.RegWrite_o !== 1'b0) begin
         errors++;
         $display("FAIL x0_wb: got %b exp 0", bus.RegWrite_o);
      end
      cyc(32'h0000_0600);
      checks++;
      if ({bus.Illegal_o, bus.RegWrite_o, bus.WbRd_o}
          !== {2'b11, 5'd1}) begin
         errors++;
         $display("FAIL ill_flag: got %b/%b/%0d exp 1/1/1",
                  bus.Illegal_o, bus.RegWrite_o, bus.WbRd_o);
      end
      cyc(32'h0, 1'b0);
      cyc(32'h0, 1'b0);
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.Illegal_o, bus.RegWrite_o, bus.WbRd_o} !== 7'd0) begin
         errors++;
         $display("FAIL ill_bubble: got %b/%b/%0d exp 0/0/0",
                  bus.Illegal_o, bus.RegWrite_o, bus.WbRd_o);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      cyc(e_beq(1, 2));
      cyc(e_jal(10));
      checks++;
      if ({bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o} !== 4'b1001) begin
         errors++;
         $display("FAIL b2b_beq: got %b exp 1001",
                  {bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o});
      end
      cyc(e_jalr(11, 1));
      checks++;
      if ({bus.ALUOp_o, bus.Jal_o, bus.Branch_o} !== 4'b1110) begin
         errors++;
         $display("FAIL b2b_jal: got %b exp 1110",
                  {bus.ALUOp_o, bus.Jal_o, bus.Branch_o});
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.Jalr_o, bus.ALUSrc_o, bus.Jal_o} !== 3'b110) begin
         errors++;
         $display("FAIL b2b_jalr: got %b exp 110",
                  {bus.Jalr_o, bus.ALUSrc_o, bus.Jal_o});
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.RegWrite_o, bus.WbRd_o} !== {1'b1, 5'd10}) begin
         errors++;
         $display("FAIL b2b_jal_wb: got %b/%0d exp 1/10",
                  bus.RegWrite_o, bus.WbRd_o);
      end
      cyc(32'h0, 1'b0);
      checks++;
      if ({bus.RegWrite_o, bus.WbRd_o} !== {1'b1, 5'd11}) begin
         errors++;
         $display("FAIL b2b_jalr_wb: got %b/%0d exp 1/11",
                  bus.RegWrite_o, bus.WbRd_o);
      end
      drain();
   endtask

   task automatic test_reset_freeze();
      cyc(e_sw(2, 1));
      cyc(32'h0, 1'b0);
      cyc(32'h0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({bus.Stall_o, bus.MemWrite_o} !== 2'b11) begin
         errors++;
         $display("FAIL rf_frozen: got %b exp 11",
                  {bus.Stall_o, bus.MemWrite_o});
      end
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs !== 21'd0) begin
         errors++;
         $display("FAIL rf_cleared: got %h exp 0", outs);
      end
      drain();
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      bus.Instr_i    = 32'h0;
      bus.Valid_i    = 1'b0;
      bus.Flush_i    = 1'b0;
      bus.MemReady_i = 1'b1;
      test_reset();
      test_load_use();
      test_fwd_priority();
      test_freeze();
      test_flush_vs_stall();
      test_x0_illegal();
      test_back_to_back();
      test_reset_freeze();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
